// File: rtl/lane_pack_pkg.sv
// Shared types and helpers for the serial-to-packed lane assembler.
// Builds with or without PACK_SUM_EN; nothing here depends on it.
package lane_pack_pkg;

  typedef enum logic {StFill, StHold} state_e;

  localparam int unsigned DefLaneW     = 8;
  localparam int unsigned DefNumLanes  = 2;
  localparam int unsigned DefHighFirst = 1;

  // Maps the k-th accepted lane of a word to its physical lane position.
  function automatic int unsigned lane_idx(input int unsigned k, input bit high_first,
                                           input int unsigned num_lanes);
    return high_first ? (num_lanes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/lane_pack_slot.sv
// One lane register of the assembly buffer: write-enable has priority over clear.
module lane_pack_slot
  import lane_pack_pkg::*;
#(
  parameter int unsigned LANE_W = DefLaneW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] d_i,
  output logic [LANE_W-1:0] q_o
);

  logic [LANE_W-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end else if (clr_i) begin
      q_q <= '0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lane_pack_accum.sv
// Packs NUM_LANES serial lanes into one word with valid/ready and early flush.
// Define PACK_SUM_EN to add out_sum_o, the wrapping sum of the lanes in the word.
module lane_pack_accum
  import lane_pack_pkg::*;
#(
  parameter int unsigned LANE_W     = DefLaneW,
  parameter int unsigned NUM_LANES  = DefNumLanes,
  parameter int unsigned HIGH_FIRST = DefHighFirst,
  localparam int unsigned CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANE_W-1:0]           in_lane_i,
  input  logic                        flush_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_LANES*LANE_W-1:0] out_data_o,
  output logic [CNT_W-1:0]            out_cnt_o
`ifdef PACK_SUM_EN
  ,
  output logic [LANE_W-1:0]           out_sum_o
`endif
);

  localparam int unsigned      DataW   = NUM_LANES * LANE_W;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(NUM_LANES);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [DataW-1:0] lanes;
  } word_t;

  if (NUM_LANES < 2) begin : g_cfg_check
    $error("lane_pack_accum: NUM_LANES must be at least 2");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     wr_k;
  logic                 in_acc, out_hs;
  logic [NUM_LANES-1:0] slot_we;
  logic [LANE_W-1:0]    slot_q [NUM_LANES];
  logic [DataW-1:0]     lanes_flat;
  word_t                word;

  assign in_acc = in_valid_i && in_ready_o;
  assign out_hs = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if ((in_acc && (cnt_q == CntFull - 1'b1)) || (flush_i && (in_acc || cnt_q != '0))) begin
          state_d = StHold;
        end
      end
      StHold: begin
        // A lane taken with the handshake plus flush re-presents a one-lane word.
        if (out_hs) begin
          state_d = (in_acc && flush_i) ? StHold : StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == StHold);
    in_ready_o  = (state_q == StFill) || out_ready_i;
  end

  always_comb begin
    wr_k  = out_hs ? '0 : cnt_q;
    cnt_d = cnt_q;
    if (out_hs) begin
      cnt_d = in_acc ? CNT_W'(1) : '0;
    end else if (in_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
    slot_we = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      slot_we[i] = in_acc && (lane_idx(32'(wr_k), HIGH_FIRST != 0, NUM_LANES) == i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    lane_pack_slot #(
      .LANE_W (LANE_W)
    ) u_slot (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (out_hs),
      .we_i  (slot_we[i]),
      .d_i   (in_lane_i),
      .q_o   (slot_q[i])
    );
    assign lanes_flat[i*LANE_W +: LANE_W] = slot_q[i];
  end

  assign word        = {cnt_q, lanes_flat};
  assign out_data_o  = word.lanes;
  assign out_cnt_o   = word.cnt;

`ifdef PACK_SUM_EN
  logic [LANE_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (out_hs) begin
      sum_d = in_acc ? in_lane_i : '0;
    end else if (in_acc) begin
      sum_d = sum_q + in_lane_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign out_sum_o = sum_q;
`endif

endmodule

// File: tb/tb_lane_pack_accum.sv
// Scoreboard bench: two instances (2 lanes high-first, 4 lanes low-first) share one stimulus.
// Honours PACK_SUM_EN when defined.
module tb_lane_pack_accum;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic [7:0]  sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_lane = '0;
  logic        ir0, ov0, ir1, ov1;
  logic [15:0] od0;
  logic [1:0]  oc0;
  logic [31:0] od1;
  logic [2:0]  oc1;
`ifdef PACK_SUM_EN
  logic [7:0]  os0, os1;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mlane [2][4];
  int         mlen [2];
  int         mpend [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  logic        m_hold, m_hs, m_acc, m_rdy, m_vld, m_hf;
  logic [31:0] m_dat;
  logic [2:0]  m_cnt;
  logic [7:0]  m_sm;
  int          m_n, m_idx;
  exp_t        m_e;

  always #5 clk = ~clk;

  lane_pack_accum #(
    .LANE_W     (8),
    .NUM_LANES  (2),
    .HIGH_FIRST (1)
  ) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (ir0),
    .in_lane_i   (in_lane),
    .flush_i     (flush),
    .out_valid_o (ov0),
    .out_ready_i (out_ready),
    .out_data_o  (od0),
    .out_cnt_o   (oc0)
`ifdef PACK_SUM_EN
    ,
    .out_sum_o   (os0)
`endif
  );

  lane_pack_accum #(
    .LANE_W     (8),
    .NUM_LANES  (4),
    .HIGH_FIRST (0)
  ) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (ir1),
    .in_lane_i   (in_lane),
    .flush_i     (flush),
    .out_valid_o (ov1),
    .out_ready_i (out_ready),
    .out_data_o  (od1),
    .out_cnt_o   (oc1)
`ifdef PACK_SUM_EN
    ,
    .out_sum_o   (os1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model, evaluated mid-cycle: inputs and outputs are stable here.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mlen[d]  = 0;
        mpend[d] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_sm = '0;
        if (d == 0) begin
          m_rdy = ir0; m_vld = ov0; m_dat = {16'h0, od0}; m_cnt = {1'b0, oc0};
          m_n = 2; m_hf = 1'b1;
`ifdef PACK_SUM_EN
          m_sm = os0;
`endif
        end else begin
          m_rdy = ir1; m_vld = ov1; m_dat = od1; m_cnt = oc1;
          m_n = 4; m_hf = 1'b0;
`ifdef PACK_SUM_EN
          m_sm = os1;
`endif
        end
        m_hold = (mpend[d] > 0);
        check($sformatf("out_valid%0d", d), m_vld, m_hold);
        check($sformatf("in_ready%0d", d), m_rdy, !m_hold || out_ready);
        m_hs = m_vld && out_ready;
        if (m_hs && mpend[d] > 0) begin
          m_e = (d == 0) ? q0.pop_front() : q1.pop_front();
          mpend[d]--;
          check($sformatf("data%0d", d), m_dat, m_e.data);
          check($sformatf("cnt%0d", d), m_cnt, m_e.cnt);
`ifdef PACK_SUM_EN
          check($sformatf("sum%0d", d), m_sm, m_e.sum);
`endif
        end
        m_acc = in_valid && m_rdy;
        if (m_acc) begin
          mlane[d][mlen[d]] = in_lane;
          mlen[d]++;
        end
        if (mlen[d] == m_n || (flush && mlen[d] > 0)) begin
          m_e = '0;
          for (int k = 0; k < mlen[d]; k++) begin
            m_idx = m_hf ? (m_n - 1 - k) : k;
            m_e.data[m_idx*8 +: 8] = mlane[d][k];
            m_e.sum = m_e.sum + mlane[d][k];
          end
          m_e.cnt = 3'(mlen[d]);
          if (d == 0) q0.push_back(m_e);
          else        q1.push_back(m_e);
          mpend[d]++;
          mlen[d] = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] l, input logic fl);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_lane  = l;
    flush    = fl;
    @(negedge clk);
    while (!ir0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", ir0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ov0, 1'b0);
    check("rst_data", od0, 16'h0);
    check("rst_cnt", oc0, 2'd0);
    rst = 1'b0;

    // Basic packing, then a lone flush (ignored on the empty 2-lane unit)
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    do_flush();
    idle(2);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    idle(2);
    // Flush carrying its own lane, flush after a full word, flush when empty
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    idle(2);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    do_flush();
    idle(2);
    do_flush();
    idle(2);
    // Wrapping sum
    send(8'hF0, 1'b0);
    send(8'h20, 1'b0);
    do_flush();
    idle(2);

    // Back-pressure on a held word, released while a lane is waiting
    out_ready = 1'b0;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    in_valid = 1'b1;
    in_lane  = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("stall_ready", ir0, 1'b0);
      check("stall_data", od0, 16'hC1C2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(8'h66, 1'b0);
    do_flush();
    idle(3);

    // Handshake, new lane and flush in one cycle
    out_ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_lane   = 8'hA3;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    idle(3);
    do_flush();
    idle(3);

    // Reset in the middle of a word
    send(8'h77, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", ov0, 1'b0);
    check("midrst_data", od0, 16'h0);
    check("midrst_cnt", oc0, 2'd0);
    check("midrst_data1", od1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    do_flush();
    idle(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_lane   = 8'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(3);
    do_flush();
    idle(5);
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
